multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences the shared ALU, the instruction/data memory port and the register file across fetch, decode, execute, memory and writeback steps.
- Drives ImmSrc to the immediate sign-extension unit and the mux selects for ALU source, result and memory address.
- Memory accesses wait on a ready handshake, guarded by a timeout that traps the core.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles spent waiting for mem_ready in any single memory state before a bus error trap.
- TO_W, 8: width of the timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- op  in  7  instr[6:0] from the instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory port completes the current access this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register and OldPC enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = ImmOp, 10 = constant 4.
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- ImmSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J.
- illegal_instr  out  1  sticky; unsupported opcode was decoded.
- bus_error  out  1  sticky; memory timeout occurred.
- instr_retired  out  1  one-cycle pulse on each transition back to FETCH.

Behaviour:
- State register is asynchronously cleared to BOOT while rst=0.
- Reset values: all enables 0, selects 00, ALUControl 000, ImmSrc 000, flags 0, timeout counter 0.
- BOOT: all enables 0; goes to FETCH on the next clock.
- Outputs are Moore-decoded from state, with three exceptions:
  - IRWrite and the fetch PCWrite are qualified by mem_ready.
  - PCWrite in BRANCH = Zero XOR funct3[0] (beq/bne).
  - ImmSrc is decoded combinationally from op: lw/addi-class 000, sw 001, branch 010, jal 011, anything else 000.
- States and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. On mem_ready: IRWrite=1, PCWrite=1, go to DECODE. Otherwise hold.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut). Next state by op:
    - 0000011 or 0100011: MEMADR.
    - 0110011: EXECR.
    - 0010011: EXECI.
    - 1100011: BRANCH.
    - 1101111: JAL.
    - other: TRAP with illegal_instr set.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. Goes to MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Waits for mem_ready, then MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
  - MEMWRITE: AdrSrc=1, MemWrite held at 1 until the mem_ready cycle, then FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALU decode, then ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALU decode, then ALUWB.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, conditional PCWrite, then FETCH.
  - TRAP: all enables 0; held until reset.
- ALU decode by funct3:
  - 000: sub if op[5] & funct7b5, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - other: add.
- Latency in cycles, including FETCH with immediate mem_ready:
  - lw 5.
  - sw 4.
  - R-type and I-type 4.
  - jal 4.
  - branch 3.
- Timeout counter:
  - Increments each cycle in FETCH, MEMREAD or MEMWRITE while mem_ready=0.
  - Clears on mem_ready or on any state change.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0: set bus_error and go to TRAP. MemWrite and IRWrite are never asserted in that cycle.
  - mem_ready=1 in the same cycle as the count hits MEM_TIMEOUT: the access completes normally and bus_error is not set.
- instr_retired is asserted on the MEMWB, MEMWRITE(ready), ALUWB and BRANCH transitions to FETCH. It is never asserted from TRAP.
- Reset mid-instruction: immediate return to BOOT; all write enables drop asynchronously.

Decomposition:
- Package control_pkg holds:
  - state enum.
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL).
  - ImmSrc, ALUSrcA/B, ResultSrc and ALUControl encodings.
- The ImmSrc encodings are shared with the sign-extension unit.
- One sub-module, alu_decoder: combinational mapping of ALUOp, funct3, funct7b5 and op[5] to ALUControl.

Test Plan:
- Reset release, then add x3,x1,x2 (op 0110011, funct3 000, funct7b5 0) with mem_ready=1:
  - BOOT, FETCH, DECODE, EXECR, ALUWB.
  - ALUControl=000 in EXECR; RegWrite=1 only in ALUWB.
  - instr_retired pulses once.
- sub with funct7b5=1 gives ALUControl=001.
- lw with mem_ready low for 3 cycles in MEMREAD:
  - Stays in MEMREAD 4 cycles with AdrSrc=1.
  - MEMWB gives ResultSrc=01, RegWrite=1.
  - ImmSrc=000 throughout.
- beq/bne with Zero=1:
  - beq (funct3 000) gives PCWrite=1 in BRANCH.
  - bne (funct3 001) gives PCWrite=0.
  - ImmSrc=010 in both.
- sw with mem_ready held 0 for MEM_TIMEOUT cycles:
  - bus_error=1 and state TRAP.
  - MemWrite=0 from the trap cycle on.
  - No further instr_retired until rst asserted.
- Opcode 0000000 gives illegal_instr=1 after DECODE, with all enables 0.
- rst asserted during MEMWRITE with MemWrite=1: MemWrite drops without a clock edge and the outputs take their reset values.

Source files
------------

// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared encodings for the multi-cycle RV32I control FSM
package control_pkg;

    typedef enum logic [3:0] {
        S_BOOT, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_JAL, S_ALUWB, S_BRANCH, S_TRAP
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// rtl/multicycle_control_alu_decoder.sv - maps ALUOp/funct fields to the ALU operation
module alu_decoder
    import control_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op[5]=1) can encode sub; addi ignores funct7
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM of the multi-cycle RV32I core
module multicycle_control
    import control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic       instr_retired
);

    state_e          state_q, state_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            illegal_q, illegal_d;
    logic            bus_err_q, bus_err_d;
    logic            wait_state, timed_out;
    alu_op_e         alu_op;

    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    // The full budget has already been waited and the bus is still silent
    assign timed_out  = wait_state && !mem_ready && (to_q == TO_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_BOOT;
            to_q      <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_q      <= to_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        to_d      = '0;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        if (wait_state && !mem_ready && !timed_out) begin
            to_d = to_q + TO_W'(1);
        end
        case (state_q)
            S_BOOT:     state_d = S_FETCH;
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_BOOT;
        endcase
        if (timed_out) begin
            state_d   = S_TRAP;
            bus_err_d = 1'b1;
        end
    end

    always_comb begin
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        instr_retired = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc     = RES_RDATA;
                RegWrite      = 1'b1;
                instr_retired = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                MemWrite      = !timed_out;
                instr_retired = mem_ready;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            S_ALUWB: begin
                RegWrite      = 1'b1;
                instr_retired = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA       = SRCA_RS1;
                alu_op        = ALUOP_SUB;
                PCWrite       = Zero ^ funct3[0];
                instr_retired = 1'b1;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );

    assign ImmSrc        = (state_q == S_BOOT) ? IMM_I : imm_src_of(op);
    assign illegal_instr = illegal_q;
    assign bus_error     = bus_err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

    localparam int MT = 255;

    logic       clk = 1'b0, rst = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0, Zero = 1'b0, mem_ready = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;
    logic       illegal_instr, bus_error, instr_retired;

    multicycle_control #(.MEM_TIMEOUT(MT), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal_instr(illegal_instr),
        .bus_error(bus_error), .instr_retired(instr_retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] res, srca, srcb;
        logic [2:0] ctl, imm;
        logic       ill, be, ret;
    } out_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, z;
        int         fw, mw;
        logic [2:0] e_imm, e_ctl;
        int         e_lat;
    } vec_t;

    int checks = 0, errors = 0;
    int cyc_n = 0, ret_at = -1, obs_at = 0;
    logic ill_m = 1'b0, be_m = 1'b0;
    logic [6:0] n_op = 7'd0;
    logic [2:0] n_f3 = 3'd0;
    logic n_f7 = 1'b0, n_z = 1'b0;
    logic [2:0] obs_imm = 3'd0, obs_ctl = 3'd0;

    function automatic logic is_legal(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b1101111: return 3'b011;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic out_t mk(input logic pcw, adr, mw, irw, rw, input logic [1:0] res, a, b,
                                input logic [2:0] ctl, imm, input logic ret);
        out_t o;
        o.pcw = pcw; o.adr = adr; o.mw = mw; o.irw = irw; o.rw = rw;
        o.res = res; o.srca = a; o.srcb = b; o.ctl = ctl; o.imm = imm;
        o.ill = ill_m; o.be = be_m; o.ret = ret;
        return o;
    endfunction

    function automatic out_t idle(input logic [2:0] imm);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b0);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic chk(input string nm, input out_t e);
        out_t a;
        a = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUControl, ImmSrc, illegal_instr, bus_error, instr_retired};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s (cycle %0d op %b): got %05h required %05h", nm, cyc_n, n_op, a, e);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, got, req);
        end
    endtask

    task automatic cyc(input string nm, input logic rdy, input out_t e);
        @(negedge clk);
        op = n_op; funct3 = n_f3; funct7b5 = n_f7; Zero = n_z; mem_ready = rdy;
        #1;
        cyc_n++;
        if (instr_retired === 1'b1 && ret_at < 0) ret_at = cyc_n;
        if (cyc_n == obs_at) obs_imm = ImmSrc;
        if (cyc_n == obs_at + 1) obs_ctl = ALUControl;
        chk(nm, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        ill_m = 1'b0; be_m = 1'b0;
        #1 chk("reset_async", idle(3'b000));
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b0;
        #1 chk("boot", idle(3'b000));
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, z, input int fw);
        n_op = o; n_f3 = f3; n_f7 = f7; n_z = z;
        cyc_n = 0; ret_at = -1; obs_at = fw + 2;
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, z,
                             input int fw, mw);
        logic [2:0] im;
        im = imm_of(o);
        set_instr(o, f3, f7, z, fw);
        for (int i = 0; i < fw; i++)
            cyc("fetch_wait", 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, im, 1'b0));
        cyc("fetch", 1'b1, mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, im, 1'b0));
        cyc("decode", rb(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, im, 1'b0));
        case (o)
            7'b0000011, 7'b0100011: begin
                cyc("memadr", rb(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, im, 1'b0));
                if (o == 7'b0000011) begin
                    for (int i = 0; i <= mw; i++)
                        cyc("memread", (i == mw), mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, im, 1'b0));
                    cyc("memwb", rb(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, im, 1'b1));
                end else begin
                    for (int i = 0; i <= mw; i++)
                        cyc("memwrite", (i == mw), mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, im, (i == mw)));
                end
            end
            7'b0110011, 7'b0010011: begin
                cyc("exec", rb(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10,
                                     (o == 7'b0110011) ? 2'b00 : 2'b01, alu_of(o, f3, f7), im, 1'b0));
                cyc("aluwb", rb(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, im, 1'b1));
            end
            7'b1100011:
                cyc("branch", rb(), mk(z ^ f3[0], 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, im, 1'b1));
            7'b1101111: begin
                cyc("jal", rb(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, im, 1'b0));
                cyc("aluwb", rb(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, im, 1'b1));
            end
            default: begin
                ill_m = 1'b1;
                for (int i = 0; i < 3; i++) cyc("illegal_trap", rb(), idle(im));
                do_reset();
            end
        endcase
    endtask

    task automatic sw_front();
        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0);
        cyc("sw_fetch", 1'b1, mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b001, 1'b0));
        cyc("sw_decode", 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b001, 1'b0));
        cyc("sw_memadr", 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 1'b0));
    endtask

    vec_t vt[16];

    initial begin
        vt[0]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 3'b000, 3'b000, 4};
        vt[1]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 3'b000, 3'b001, 4};
        vt[2]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3, 3'b000, 3'b000, 8};
        vt[3]  = '{7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 3'b010, 3'b001, 3};
        vt[4]  = '{7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0, 3'b010, 3'b001, 3};
        vt[5]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 2, 1, 3'b001, 3'b000, 7};
        vt[6]  = '{7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 3'b011, 3'b000, 4};
        vt[7]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, 3'b000, 3'b000, 4};
        vt[8]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 0, 0, 3'b000, 3'b101, 4};
        vt[9]  = '{7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0, 3'b000, 3'b011, 4};
        vt[10] = '{7'b0110011, 3'b111, 1'b1, 1'b0, 0, 0, 3'b000, 3'b010, 4};
        vt[11] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 1, 0, 3'b010, 3'b001, 4};
        vt[12] = '{7'b0100011, 3'b010, 1'b0, 1'b0, 0, MT, 3'b001, 3'b000, 4 + MT};
        vt[13] = '{7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0, 3'b000, 3'b000, -1};
        vt[14] = '{7'b1110011, 3'b000, 1'b0, 1'b0, 0, 0, 3'b000, 3'b000, -1};
        vt[15] = '{7'b0000011, 3'b000, 1'b0, 1'b0, 1, 0, 3'b000, 3'b000, 6};

        do_reset();
        for (int k = 0; k < 16; k++) begin
            run_instr(vt[k].op, vt[k].f3, vt[k].f7, vt[k].z, vt[k].fw, vt[k].mw);
            chk_int($sformatf("latency[%0d]", k), ret_at, vt[k].e_lat);
            chk_int($sformatf("immsrc[%0d]", k), int'(obs_imm), int'(vt[k].e_imm));
            chk_int($sformatf("aluctl[%0d]", k), int'(obs_ctl), int'(vt[k].e_ctl));
        end

        for (int k = 0; k < 150; k++) begin
            logic [6:0] o;
            case ($urandom_range(6, 0))
                0: o = 7'b0000011;
                1: o = 7'b0100011;
                2: o = 7'b0110011;
                3: o = 7'b0010011;
                4: o = 7'b1100011;
                5: o = 7'b1101111;
                default: begin
                    o = 7'($urandom);
                    while (is_legal(o)) o = 7'($urandom);
                end
            endcase
            run_instr(o, 3'($urandom), rb(), rb(), int'($urandom_range(3, 0)), int'($urandom_range(4, 0)));
        end

        // Store that never gets mem_ready: MemWrite must drop in the trap cycle
        sw_front();
        for (int i = 0; i < MT; i++)
            cyc("sw_wait", 1'b0, mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 1'b0));
        cyc("sw_timeout", 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 1'b0));
        be_m = 1'b1;
        for (int i = 0; i < 6; i++) cyc("bus_trap", rb(), idle(3'b001));
        chk_int("trap_no_retire", ret_at, -1);
        do_reset();

        // Reset asserted while a store is being driven
        sw_front();
        cyc("sw_pre_rst", 1'b0, mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 1'b0));
        #1 rst = 1'b0;
        #1 chk("rst_mid_write", idle(3'b000));
        @(negedge clk);
        rst = 1'b1;
        #1 chk("boot_after_rst", idle(3'b000));
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
